// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_bank_arbiter
// Description : Round-robin REQ/GNT owner of the LED bank, with a minimum hold
//               time per owner and a one-cycle blank gap between owners.
//               Optional macro LED_ARB_PRIO_EN makes source 0 high priority.
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank_arbiter #(
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 500
) (
   input  logic             SCLK,
   input  logic             RST,
   input  logic [2:0]       REQ,
   input  logic [WIDTH-1:0] PAT0,
   input  logic [WIDTH-1:0] PAT1,
   input  logic [WIDTH-1:0] PAT2,
   output logic [2:0]       GNT,
   output logic [WIDTH-1:0] LD,
   output logic             BUSY
);

   localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
   localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_CYCLES);
   localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t              r_state;
   logic [2:0]          r_gnt;
   logic [WIDTH-1:0]    r_ld;
   logic [c_hold_w-1:0] r_hold;
   logic [1:0]          r_rr_last;

   state_t              w_state_nxt;
   logic [2:0]          w_gnt_nxt;
   logic [WIDTH-1:0]    w_ld_nxt;
   logic [c_hold_w-1:0] w_hold_nxt;
   logic [1:0]          w_rr_nxt;

   logic [1:0]          w_win;
   logic [1:0]          w_own;
   logic [WIDTH-1:0]    w_win_pat;
   logic [WIDTH-1:0]    w_own_pat;
   logic                w_any;
   logic                w_own_req;
   logic                w_others;
   logic                w_hold_done;
   logic                w_preempt;

   // Search order is last+1, last+2, last (mod 3); first requester wins.
   function automatic logic [1:0] pick_rr(input logic [2:0] req,
                                          input logic [1:0] last);
      logic [1:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      case (last)
         2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
         2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
         default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      endcase
      if (req[c0])
         return c0;
      else if (req[c1])
         return c1;
      else
         return c2;
   endfunction

   assign w_any = |REQ;

`ifdef LED_ARB_PRIO_EN
   assign w_win = REQ[0] ? 2'd0 : pick_rr(REQ, r_rr_last);
`else
   assign w_win = pick_rr(REQ, r_rr_last);
`endif

   always_comb begin
      case (r_gnt)
         3'b010:  w_own = 2'd1;
         3'b100:  w_own = 2'd2;
         default: w_own = 2'd0;
      endcase
   end

   always_comb begin
      case (w_win)
         2'd1:    w_win_pat = PAT1;
         2'd2:    w_win_pat = PAT2;
         default: w_win_pat = PAT0;
      endcase
   end

   always_comb begin
      case (w_own)
         2'd1:    w_own_pat = PAT1;
         2'd2:    w_own_pat = PAT2;
         default: w_own_pat = PAT0;
      endcase
   end

   assign w_own_req   = |(REQ & r_gnt);
   assign w_others    = |(REQ & ~r_gnt);
   assign w_hold_done = (r_hold == c_hold_max);

`ifdef LED_ARB_PRIO_EN
   // The high-priority owner is never pre-empted; it leaves only on release.
   assign w_preempt = w_hold_done && w_others && (w_own != 2'd0);
`else
   assign w_preempt = w_hold_done && w_others;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ld_nxt    = r_ld;
      w_hold_nxt  = r_hold;
      w_rr_nxt    = r_rr_last;
      case (r_state)
         ST_IDLE, ST_GAP: begin
            w_gnt_nxt  = 3'b000;
            w_ld_nxt   = '0;
            w_hold_nxt = '0;
            if (w_any) begin
               w_state_nxt = ST_OWN;
               w_gnt_nxt   = 3'b001 << w_win;
               w_ld_nxt    = w_win_pat;
               w_rr_nxt    = w_win;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!w_own_req || w_preempt) begin
               w_state_nxt = ST_GAP;
               w_gnt_nxt   = 3'b000;
               w_ld_nxt    = '0;
               w_hold_nxt  = '0;
            end else begin
               w_ld_nxt = w_own_pat;
               if (!w_hold_done)
                  w_hold_nxt = r_hold + c_hold_one;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 3'b000;
            w_ld_nxt    = '0;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge SCLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 3'b000;
         r_ld      <= '0;
         r_hold    <= '0;
         r_rr_last <= 2'd2;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_ld      <= w_ld_nxt;
         r_hold    <= w_hold_nxt;
         r_rr_last <= w_rr_nxt;
      end
   end

   assign GNT  = r_gnt;
   assign LD   = r_ld;
   assign BUSY = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_bank_arbiter
// Description : Self-checking bench for led_bank_arbiter (HOLD_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bank_arbiter;

   localparam int HOLD = 4;
`ifdef LED_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        SCLK = 1'b0;
   logic        rst  = 1'b1;
   logic [2:0]  req  = 3'b000;
   logic [15:0] pat0 = '0;
   logic [15:0] pat1 = '0;
   logic [15:0] pat2 = '0;
   logic [2:0]  gnt;
   logic [15:0] ld;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner id (-1 = none), edges owned since grant, gap flag.
   int          m_owner = -1;
   int          m_age   = 0;
   int          m_last  = 2;
   bit          m_gap   = 1'b0;
   logic [15:0] m_ld    = '0;

   led_bank_arbiter #(.WIDTH(16), .HOLD_CYCLES(HOLD)) dut (
      .SCLK(SCLK), .RST(rst), .REQ(req),
      .PAT0(pat0), .PAT1(pat1), .PAT2(pat2),
      .GNT(gnt), .LD(ld), .BUSY(busy)
   );

   always #5 SCLK = ~SCLK;

   function automatic logic [15:0] pat_of(input int i);
      if (i == 1) return pat1;
      if (i == 2) return pat2;
      return pat0;
   endfunction

   function automatic int m_pick(input logic [2:0] rq, input int last);
      if (PRIO && rq[0]) return 0;
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (last + k) % 3;
         if (rq[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_owner = -1; m_age = 0; m_last = 2; m_gap = 1'b0;
      end else if (m_owner >= 0) begin
         logic [2:0] others;
         others = req & ~(3'b001 << m_owner);
         if (!req[m_owner] ||
             (m_age >= HOLD && others != 3'b000 && !(PRIO && m_owner == 0))) begin
            m_owner = -1; m_gap = 1'b1;
         end else begin
            m_age++;
            m_ld = pat_of(m_owner);
         end
      end else begin
         m_gap = 1'b0;
         if (req != 3'b000) begin
            m_owner = m_pick(req, m_last);
            m_last  = m_owner;
            m_age   = 0;
            m_ld    = pat_of(m_owner);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model on the same edge, then compare after settling.
   task automatic tick();
      @(posedge SCLK);
      model_step();
      #1;
      check("model_gnt", {29'd0, gnt}, (m_owner >= 0) ? 32'(3'b001 << m_owner) : 32'd0);
      check("model_ld", {16'd0, ld}, (m_owner >= 0) ? {16'd0, m_ld} : 32'd0);
      check("model_busy", {31'd0, busy}, {31'd0, (m_owner >= 0) || m_gap});
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 3'b000;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  gnt;
      logic [15:0] ld;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic [2:0] rq, input logic [2:0] g,
                          input logic [15:0] l, input logic b);
      vec_t v;
      v.rst = r; v.req = rq; v.gnt = g; v.ld = l; v.busy = b;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] tpat [3];
      logic [2:0]  exp_next;

      // Reset under full request, then full rotation 0 -> 1 -> 2 -> 0.
      tpat[0] = 16'hAAAA; tpat[1] = 16'h00FF; tpat[2] = 16'hF00F;
      add_vec(1'b1, 3'b111, 3'b000, 16'h0000, 1'b0);
      add_vec(1'b1, 3'b111, 3'b000, 16'h0000, 1'b0);
      for (int o = 0; o < 3; o++) begin
         for (int c = 0; c < HOLD + 1; c++)
            add_vec(1'b0, 3'b111, 3'(1 << o), tpat[o], 1'b1);
         add_vec(1'b0, 3'b111, 3'b000, 16'h0000, 1'b1);
      end
      add_vec(1'b0, 3'b111, 3'b001, 16'hAAAA, 1'b1);

      pat0 = tpat[0]; pat1 = tpat[1]; pat2 = tpat[2];
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst;
         req = vecs[i].req;
         tick();
         check($sformatf("vec%0d_gnt", i), {29'd0, gnt}, {29'd0, vecs[i].gnt});
         check($sformatf("vec%0d_ld", i), {16'd0, ld}, {16'd0, vecs[i].ld});
         check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      end

      // Sole requester keeps the bank; pattern change shows up one cycle later.
      do_reset();
      pat1 = 16'h00FF; req = 3'b010;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("sole_gnt", {29'd0, gnt}, 32'b010);
         check("sole_ld", {16'd0, ld}, 32'h00FF);
      end
      pat1 = 16'h0F0F;
      tick();
      check("sole_patchg_ld", {16'd0, ld}, 32'h0F0F);

      // Owner 0 releases at hold_cnt=1 while source 2 waits.
      do_reset();
      pat0 = 16'h1234; pat2 = 16'h5678; req = 3'b101;
      tick();
      check("rel_grant0", {29'd0, gnt}, 32'b001);
      tick();
      req = 3'b100;
      tick();
      check("rel_gap_gnt", {29'd0, gnt}, 32'b000);
      check("rel_gap_ld", {16'd0, ld}, 32'h0000);
      check("rel_gap_busy", {31'd0, busy}, 32'd1);
      tick();
      check("rel_grant2", {29'd0, gnt}, 32'b100);
      check("rel_grant2_ld", {16'd0, ld}, 32'h5678);

      // Reset in the middle of source 2 ownership: no gap, source 0 first after.
      do_reset();
      req = 3'b100;
      tick(); tick();
      check("rst_own2", {29'd0, gnt}, 32'b100);
      rst = 1'b1; req = 3'b111;
      tick();
      check("rst_mid_gnt", {29'd0, gnt}, 32'b000);
      check("rst_mid_ld", {16'd0, ld}, 32'h0000);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_after_gnt", {29'd0, gnt}, 32'b001);

      // Owner 1, then sources 0 and 2 start requesting at hold_cnt=0.
      do_reset();
      req = 3'b010;
      tick();
      check("pre_own1", {29'd0, gnt}, 32'b010);
      req = 3'b111;
      for (int i = 0; i < HOLD; i++) begin
         tick();
         check("pre_hold1", {29'd0, gnt}, 32'b010);
      end
      tick();
      check("pre_gap", {29'd0, gnt}, 32'b000);
      check("pre_gap_busy", {31'd0, busy}, 32'd1);
      tick();
      exp_next = PRIO ? 3'b001 : 3'b100;
      check("pre_next", {29'd0, gnt}, {29'd0, exp_next});

      // Randomised traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
         pat0 = 16'($urandom); pat1 = 16'($urandom); pat2 = 16'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
